// File: rtl/bus_rr_pkg.sv
// Shared types, defaults and the round-robin pick function for the broadcast bus router.
package bus_rr_pkg;

  typedef enum logic [1:0] {IDLE, POP, PUSH} bus_state_e;

  localparam int         DEF_ID_W  = 8;
  localparam logic [7:0] DEF_BCAST = 8'hFF;

  // Device indices fit in 8 bits because the bus carries at most 255 devices.
  localparam int IDX_W     = 8;
  localparam int IDX_XW    = IDX_W + 1;
  localparam int MAX_DRVRS = 256;

  // First requester strictly after ptr, wrapping modulo n; returns ptr when nothing is requesting.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_DRVRS-1:0] req,
                                              input logic [IDX_W-1:0]     ptr,
                                              input int unsigned          n);
    logic [IDX_XW-1:0] idx;
    logic              found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = {1'b0, ptr} + IDX_XW'(k);
      if (idx >= IDX_XW'(n)) idx = idx - IDX_XW'(n);
      if (!found && req[idx[IDX_W-1:0]]) begin
        rr_pick = idx[IDX_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: lowest priority goes to the device right at ptr.
module bus_rr_pick
  import bus_rr_pkg::*;
#(
  parameter int DRVRS = 4
) (
  input  logic [DRVRS-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  assign any     = |req;
  assign gnt_idx = rr_pick(MAX_DRVRS'(req), ptr, DRVRS);

endmodule

// File: rtl/bus_rr_router.sv
// Round-robin broadcast bus router: pops one device FIFO head, delivers it unicast or broadcast.
// Optional BUS_STATS_EN adds saturating transfer/drop counters.
module bus_rr_router
  import bus_rr_pkg::*;
#(
  parameter int              BITS  = 16,
  parameter int              DRVRS = 4,
  parameter int              ID_W  = DEF_ID_W,
  parameter logic [ID_W-1:0] BCAST = ID_W'(DEF_BCAST)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DRVRS-1:0]      pndng,
  input  logic [DRVRS*BITS-1:0] D_pop,
  output logic [DRVRS-1:0]      pop,
  output logic [DRVRS-1:0]      push,
  output logic [BITS-1:0]       D_push,
  output logic                  drop,
  output bus_state_e            dbg_state
`ifdef BUS_STATS_EN
  ,
  output logic [31:0]           xfer_cnt,
  output logic [31:0]           drop_cnt
`endif
);

  if (BITS < ID_W + 1) begin : g_bits_chk
    $error("bus_rr_router: BITS must be at least ID_W+1");
  end
  if (DRVRS < 2 || DRVRS > 255) begin : g_drvrs_chk
    $error("bus_rr_router: DRVRS must be in 2..255");
  end
  if (32'(BCAST) < 32'(DRVRS)) begin : g_bcast_chk
    $error("bus_rr_router: BCAST must not alias a device ID");
  end

  // Handshake: pop[i] is a one-cycle dequeue strobe for device i's head word; the head is
  // captured on the same edge that raises pop. push[i] is a one-cycle write strobe qualifying
  // D_push for device i; devices cannot stall the bus.

  bus_state_e       state, state_n;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [BITS-1:0]  pkt_q, pkt_n;
  logic [DRVRS-1:0] pop_n, push_n;
  logic [BITS-1:0]  d_push_n;
  logic             drop_n;
  logic [ID_W-1:0]  dest;
  logic [IDX_W-1:0] gnt_idx;
  logic             any;

  bus_rr_pick #(.DRVRS(DRVRS)) u_pick (
    .req     (pndng),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign dest      = pkt_q[BITS-1 -: ID_W];
  assign dbg_state = state;

  // rr_ptr doubles as the current source index once a winner has been latched.
  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    pkt_n    = pkt_q;
    pop_n    = '0;
    push_n   = '0;
    d_push_n = D_push;
    drop_n   = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_n  = POP;
          rr_ptr_n = gnt_idx;
          for (int i = 0; i < DRVRS; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
              pop_n[i] = 1'b1;
              pkt_n    = D_pop[i*BITS +: BITS];
            end
          end
        end
      end
      POP: begin
        state_n  = PUSH;
        d_push_n = pkt_q;
        if (32'(dest) < 32'(DRVRS)) begin
          for (int i = 0; i < DRVRS; i++) push_n[i] = (32'(dest) == i);
        end else if (dest == BCAST) begin
          for (int i = 0; i < DRVRS; i++) push_n[i] = (rr_ptr != IDX_W'(i));
        end else begin
          drop_n = 1'b1;
        end
      end
      PUSH:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rr_ptr <= IDX_W'(DRVRS - 1);
      pkt_q  <= '0;
      pop    <= '0;
      push   <= '0;
      D_push <= '0;
      drop   <= 1'b0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      pkt_q  <= pkt_n;
      pop    <= pop_n;
      push   <= push_n;
      D_push <= d_push_n;
      drop   <= drop_n;
    end
  end

`ifdef BUS_STATS_EN
  // A broadcast is one transfer regardless of how many devices receive it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_cnt <= '0;
      drop_cnt <= '0;
    end else if (state == PUSH) begin
      if (|push && xfer_cnt != 32'hFFFF_FFFF) xfer_cnt <= xfer_cnt + 32'd1;
      if (drop && drop_cnt != 32'hFFFF_FFFF)  drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule
